exu_gpr_rf: RTL



---
 rtl/exu_gpr_rf_if.sv | 17 +
 rtl/exu_gpr_rf.sv | 134 +++++++++++++
 2 files changed

// File: rtl/exu_gpr_rf_if.sv
// Register-file access bundle between execute handlers (mst) and the GPR file (slv).
// Two read ports with combinational data return, one single-cycle write port.
interface exu_gpr_if_t;
  localparam int RV_XLEN   = 32;
  localparam int RV_GPR_AW = 5;

  logic [RV_GPR_AW-1:0] ra1;
  logic [RV_GPR_AW-1:0] ra2;
  logic [RV_GPR_AW-1:0] wa;
  logic                 wen;
  logic [RV_XLEN-1:0]   wd;
  logic [RV_XLEN-1:0]   rd1;
  logic [RV_XLEN-1:0]   rd2;

  modport slv (input ra1, ra2, wa, wen, wd, output rd1, rd2);
  modport mst (output ra1, ra2, wa, wen, wd, input rd1, rd2);
endinterface

// File: rtl/exu_gpr_rf.sv
// Execute-stage GPR file: 2 async read ports, EXU write port, late-writeback port with
// per-register pending scoreboard, and a post-reset sequencer that zeroes x1..x31.
module exu_gpr_rf #(
  parameter bit     INIT_CLEAR = 1'b1,
  localparam int    RV_XLEN    = 32,
  localparam int    RV_GPR_AW  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exu_gpr_if_t.slv             gpr_slv,
  output logic                 o_init_done,
  input  logic                 i_pend_set,
  input  logic [RV_GPR_AW-1:0] i_pend_wa,
  output logic                 o_busy1,
  output logic                 o_busy2,
  input  logic                 i_lwb_vld,
  output logic                 o_lwb_rdy,
  input  logic [RV_GPR_AW-1:0] i_lwb_wa,
  input  logic [RV_XLEN-1:0]   i_lwb_wd
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [RV_GPR_AW-1:0]   r_clr_cnt;
  logic [RV_XLEN-1:0]     r_gpr [32];
  logic [31:1]            r_pend;
  logic [31:1]            w_pend_next;
  logic [31:0]            w_pend_vec;

  logic                   w_run;
  logic                   w_exu_wr_req;
  logic                   w_exu_wr;
  logic                   w_lwb_acc;
  logic                   w_pend_set;
  logic                   w_lwb_clr;
  logic                   w_wr_en;
  logic [RV_GPR_AW-1:0]   w_wr_addr;
  logic [RV_XLEN-1:0]     w_wr_data;

  assign w_run        = (r_state == S_RUN);
  assign w_exu_wr_req = gpr_slv.wen && (gpr_slv.wa != '0);
  assign w_exu_wr     = w_run && w_exu_wr_req;
  assign w_lwb_acc    = i_lwb_vld && o_lwb_rdy;
  assign w_pend_set   = w_run && i_pend_set && (i_pend_wa != '0);
  assign w_lwb_clr    = w_lwb_acc && (i_lwb_wa != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: the clear pass ends once x31 has been written
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_INIT) begin
      if (!INIT_CLEAR || (r_clr_cnt == 5'd31)) begin
        w_state_next = S_RUN;
      end
    end
  end

  // Outputs: EXU write port always beats the late writeback
  always_comb begin
    o_init_done = w_run;
    o_lwb_rdy   = w_run && !w_exu_wr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= 5'd1;
    end else if (r_state == S_INIT) begin
      r_clr_cnt <= r_clr_cnt + 5'd1;
    end
  end

  // One physical write port; sources are mutually exclusive by construction
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    if ((r_state == S_INIT) && INIT_CLEAR) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_clr_cnt;
    end else if (w_exu_wr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = gpr_slv.wa;
      w_wr_data = gpr_slv.wd;
    end else if (w_lwb_clr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = i_lwb_wa;
      w_wr_data = i_lwb_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_gpr[w_wr_addr] <= w_wr_data;
    end
  end

  assign gpr_slv.rd1 = (gpr_slv.ra1 == '0) ? '0 : r_gpr[gpr_slv.ra1];
  assign gpr_slv.rd2 = (gpr_slv.ra2 == '0) ? '0 : r_gpr[gpr_slv.ra2];

  // Set beats clear so a newly issued load supersedes the one completing
  for (genvar gi = 1; gi < 32; gi++) begin : g_pend
    always_comb begin
      w_pend_next[gi] = r_pend[gi];
      if (w_pend_set && (i_pend_wa == 5'(gi))) begin
        w_pend_next[gi] = 1'b1;
      end else if (w_lwb_clr && (i_lwb_wa == 5'(gi))) begin
        w_pend_next[gi] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  assign w_pend_vec = {r_pend, 1'b0};
  assign o_busy1    = w_pend_vec[gpr_slv.ra1];
  assign o_busy2    = w_pend_vec[gpr_slv.ra2];

endmodule
